player_input_ctrl: RTL and testbench
====================================

# player_input_ctrl

Parametrised per-player joystick and pause-button front end for the Pacman top level. It replaces the ad-hoc combinational direction latches with one block per design. For each of `NUM_PLAYERS` controllers it:
- synchronises and debounces the raw joystick and pause inputs;
- resolves a 2-bit heading against the maze collision flags, buffering a blocked turn until it becomes legal;
- provides a global pause toggle.

Outputs feed the VGA sprite logic and the processor memory-mapped I/O.

## Interface
- `NUM_PLAYERS`, 2, number of controllers; all per-player buses are packed with player 0 in the LSBs.
- `DEBOUNCE_CYCLES`, 16, consecutive stable synchronised samples required to accept a new input level (≥1).
- `PEND_TIMEOUT`, 64, cycles a buffered turn survives before being dropped; 0 means no timeout.

- `clock`  in  1  system clock, all logic rising-edge.
- `resetn`  in  1  synchronous, active-low reset.
- `joy_n`, `joy_e`, `joy_s`, `joy_w`  in  NUM_PLAYERS each  raw active-high joystick contacts, asynchronous.
- `pause_btn`  in  NUM_PLAYERS  raw active-high pause buttons, asynchronous; any player may pause.
- `blocked`  in  4*NUM_PLAYERS  per-player collision flags, nibble `{up,left,down,right}`, synchronous to `clock`.
- `direction`  out  2*NUM_PLAYERS  heading: 00 east, 01 south, 10 west, 11 north.
- `dir_change`  out  NUM_PLAYERS  one-cycle pulse when that player's `direction` updates.
- `moving`  out  NUM_PLAYERS  registered: 1 when current heading is not blocked and not paused.
- `pend_valid`  out  NUM_PLAYERS  buffered turn outstanding.
- `paused`  out  1  global pause level.

## Operation
**Input conditioning**
- Each raw bit passes through a 2-flop synchroniser, then a per-bit debouncer.
- Each debouncer has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
- The counter resets to 0 whenever the synchronised level equals the debounced level.
- Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.

**Request decode** (debounced, priority E > S > W > N, no contact → no request)
- Request valid, differs from `direction`, and `blocked[req]`=0: apply it. `direction`<=req, pulse `dir_change`, clear pending.
- Request valid, differs from `direction`, and `blocked[req]`=1: go to state PENDING with `pend_dir`=req and the timeout counter cleared.
- Request equal to current `direction`: no action. Any pending turn is kept.

**Per-player FSM** (states IDLE, PENDING)
- IDLE→PENDING: on a blocked request.
- PENDING→IDLE, with `direction`<=`pend_dir` and a `dir_change` pulse: when `blocked[pend_dir]`=0.
- PENDING→PENDING: when a different new request arrives, overwrite `pend_dir` and restart the timeout.
- PENDING→IDLE with no change: when the timeout counter reaches `PEND_TIMEOUT` (if nonzero).
- In the same cycle, a new legal request takes precedence over applying the pending turn.

**Pause**
- A rising edge of any debounced `pause_btn` toggles `paused`. Simultaneous edges from several players count as one toggle.
- While `paused`=1: `direction` frozen, all FSMs forced to IDLE, `dir_change`=0, `moving`=0.
- Debouncers keep running while paused.

**Moving**
- `moving` <= ~`paused` & ~`blocked[direction]`, registered.

## Timing
- Reset values: `direction`=00 for all players, `dir_change`=0, `moving`=0, `pend_valid`=0, `paused`=0. Synchronisers, debouncers and counters are all cleared.
- Reset asserted mid-debounce or mid-PENDING discards all state on the next edge.
- Latency from raw level held stable to `direction` update is `DEBOUNCE_CYCLES`+3 cycles (2 sync + debounce + 1 decode register). `dir_change` is coincident with the update.
- Buffered-turn apply: `direction` updates 1 cycle after the `blocked[pend_dir]` deassertion is sampled.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised samples is never seen.
- Timeout counter saturates. `pend_valid` drops on the cycle after the counter hits `PEND_TIMEOUT`.

## Configuration
- `INPUT_TURN_BUFFER_EN` defined: PENDING state, timeout counter and `pend_valid` behave as above.
- `INPUT_TURN_BUFFER_EN` not defined:
  - Blocked requests are discarded.
  - FSM stays IDLE.
  - `pend_valid` is tied 0.
  - Timeout logic is not synthesised.
  - `PEND_TIMEOUT` is ignored.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `PEND_TIMEOUT`=8, `NUM_PLAYERS`=2.
- Reset: hold `resetn`=0 with `joy_s`=11 → all outputs 0 and `direction`=0000. Release `resetn`, `blocked`=0 → both `direction` fields = 01 exactly 7 cycles later, `dir_change`=11 for one cycle.
- Debounce: pulse `joy_w[0]` for 3 cycles → no change. Hold it for 10 cycles → `direction[1:0]`=10.
- Buffered turn (macro defined): P0 heading east, `blocked[3]` (up) =1, hold `joy_n[0]` → `pend_valid[0]`=1 and `direction` unchanged. Clear `blocked[3]` → next cycle `direction[1:0]`=11, `pend_valid[0]`=0.
- Timeout: same as above but keep `blocked[3]`=1 → `pend_valid[0]` drops after 8 cycles and `direction` stays 00. With the macro undefined, `pend_valid` is never 1.
- Pause: debounced rising edges on both `pause_btn` bits in the same cycle → `paused`=1 (single toggle), `moving`=00, and joystick changes are ignored. A second press → `paused`=0.
- Priority: `joy_e[1]` and `joy_n[1]` asserted together, nothing blocked → `direction[3:2]`=00.

Source files
------------

// File: rtl/player_input_ctrl.sv
// Per-player joystick/pause front end: 2-flop sync, debounce, heading resolve against collision
// flags, global pause toggle. Define INPUT_TURN_BUFFER_EN to hold a blocked turn until it is legal.
module player_input_ctrl #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PEND_TIMEOUT    = 64
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [NUM_PLAYERS-1:0]   joy_n,
    input  logic [NUM_PLAYERS-1:0]   joy_e,
    input  logic [NUM_PLAYERS-1:0]   joy_s,
    input  logic [NUM_PLAYERS-1:0]   joy_w,
    input  logic [NUM_PLAYERS-1:0]   pause_btn,
    input  logic [4*NUM_PLAYERS-1:0] blocked,
    output logic [2*NUM_PLAYERS-1:0] direction,
    output logic [NUM_PLAYERS-1:0]   dir_change,
    output logic [NUM_PLAYERS-1:0]   moving,
    output logic [NUM_PLAYERS-1:0]   pend_valid,
    output logic                     paused
);

    localparam int NB = 5 * NUM_PLAYERS;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [NB-1:0]            raw;
    logic [NB-1:0]            sync1;
    logic [NB-1:0]            sync2;
    logic [NB-1:0]            deb;
    logic [DW-1:0]            deb_cnt [NB];
    logic [NUM_PLAYERS-1:0]   deb_e;
    logic [NUM_PLAYERS-1:0]   deb_s;
    logic [NUM_PLAYERS-1:0]   deb_w;
    logic [NUM_PLAYERS-1:0]   deb_n;
    logic [NUM_PLAYERS-1:0]   deb_pause;
    logic [NUM_PLAYERS-1:0]   pause_prev;
    logic                     pause_rise;
    logic [NUM_PLAYERS-1:0]   req_valid;
    logic [NUM_PLAYERS-1:0]   new_req;
    logic [NUM_PLAYERS-1:0]   req_blk;
    logic [NUM_PLAYERS-1:0]   head_blk;
    logic [1:0]               req [NUM_PLAYERS];
    logic [3:0]               nib [NUM_PLAYERS];
    state_t                   state_q [NUM_PLAYERS];
    state_t                   state_d [NUM_PLAYERS];
    logic [2*NUM_PLAYERS-1:0] dir_d;
    logic [NUM_PLAYERS-1:0]   dc_d;
    logic [NUM_PLAYERS-1:0]   mov_d;

`ifdef INPUT_TURN_BUFFER_EN
    localparam int TW = (PEND_TIMEOUT > 0) ? $clog2(PEND_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(PEND_TIMEOUT);

    logic [2*NUM_PLAYERS-1:0] pdir_q;
    logic [2*NUM_PLAYERS-1:0] pdir_d;
    logic [TW-1:0]            tcnt_q [NUM_PLAYERS];
    logic [TW-1:0]            tcnt_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]   pend_blk;
`endif

    assign raw       = {pause_btn, joy_n, joy_w, joy_s, joy_e};
    assign deb_e     = deb[0 +: NUM_PLAYERS];
    assign deb_s     = deb[NUM_PLAYERS +: NUM_PLAYERS];
    assign deb_w     = deb[2*NUM_PLAYERS +: NUM_PLAYERS];
    assign deb_n     = deb[3*NUM_PLAYERS +: NUM_PLAYERS];
    assign deb_pause = deb[4*NUM_PLAYERS +: NUM_PLAYERS];
    assign pause_rise = |(deb_pause & ~pause_prev);

    // A bit's debounced level flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= ~deb[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Heading codes double as indices into the {up,left,down,right} collision nibble.
    always_comb begin
        req_valid = '0;
        new_req   = '0;
        req_blk   = '0;
        head_blk  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            nib[p] = blocked[4*p +: 4];
            req[p] = 2'd3;
            if (deb_e[p]) begin
                req[p] = 2'd0;
            end else if (deb_s[p]) begin
                req[p] = 2'd1;
            end else if (deb_w[p]) begin
                req[p] = 2'd2;
            end
            req_valid[p] = deb_e[p] | deb_s[p] | deb_w[p] | deb_n[p];
            new_req[p]   = req_valid[p] && (req[p] != direction[2*p +: 2]);
            req_blk[p]   = nib[p][req[p]];
            head_blk[p]  = nib[p][direction[2*p +: 2]];
        end
    end

`ifdef INPUT_TURN_BUFFER_EN
    always_comb begin
        pend_blk   = '0;
        pend_valid = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            pend_blk[p]   = nib[p][pdir_q[2*p +: 2]];
            pend_valid[p] = (state_q[p] == PENDING);
        end
    end
`else
    assign pend_valid = '0;
`endif

    always_comb begin
        dir_d   = direction;
        dc_d    = '0;
        mov_d   = '0;
        state_d = state_q;
`ifdef INPUT_TURN_BUFFER_EN
        pdir_d  = pdir_q;
        tcnt_d  = tcnt_q;
`endif
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            mov_d[p] = ~paused & ~head_blk[p];
            if (paused) begin
                state_d[p] = IDLE;
            end else if (new_req[p] && !req_blk[p]) begin
                // A fresh legal request wins over applying any buffered turn.
                dir_d[2*p +: 2] = req[p];
                dc_d[p]         = 1'b1;
                state_d[p]      = IDLE;
`ifdef INPUT_TURN_BUFFER_EN
            end else if (new_req[p] && (state_q[p] == IDLE || req[p] != pdir_q[2*p +: 2])) begin
                state_d[p]       = PENDING;
                pdir_d[2*p +: 2] = req[p];
                tcnt_d[p]        = '0;
            end else if (state_q[p] == PENDING) begin
                if (!pend_blk[p]) begin
                    dir_d[2*p +: 2] = pdir_q[2*p +: 2];
                    dc_d[p]         = 1'b1;
                    state_d[p]      = IDLE;
                end else if (PEND_TIMEOUT != 0 && tcnt_q[p] == TO_LAST) begin
                    state_d[p] = IDLE;
                end else if (tcnt_q[p] != TO_LAST) begin
                    tcnt_d[p] = tcnt_q[p] + TW'(1);
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            direction  <= '0;
            dir_change <= '0;
            moving     <= '0;
            paused     <= 1'b0;
            pause_prev <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                state_q[p] <= IDLE;
            end
        end else begin
            direction  <= dir_d;
            dir_change <= dc_d;
            moving     <= mov_d;
            paused     <= paused ^ pause_rise;
            pause_prev <= deb_pause;
            state_q    <= state_d;
        end
    end

`ifdef INPUT_TURN_BUFFER_EN
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pdir_q <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                tcnt_q[p] <= '0;
            end
        end else begin
            pdir_q <= pdir_d;
            tcnt_q <= tcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_player_input_ctrl.sv
// Bench for player_input_ctrl: directed scenarios plus random input segments, with every cycle's
// outputs predicted by a behavioural model and checked through an expected-output queue.
module tb_player_input_ctrl;

    localparam int NP  = 2;
    localparam int DEB = 4;
    localparam int TO  = 8;
    localparam int NB  = 5 * NP;
    localparam int W   = 11;

    logic          clock;
    logic          resetn;
    logic [NP-1:0] joy_n, joy_e, joy_s, joy_w, pause_btn;
    logic [4*NP-1:0] blocked;
    logic [2*NP-1:0] direction;
    logic [NP-1:0] dir_change, moving, pend_valid;
    logic          paused;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] exp_q[$];

    player_input_ctrl #(
        .NUM_PLAYERS    (NP),
        .DEBOUNCE_CYCLES(DEB),
        .PEND_TIMEOUT   (TO)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .joy_n     (joy_n),
        .joy_e     (joy_e),
        .joy_s     (joy_s),
        .joy_w     (joy_w),
        .pause_btn (pause_btn),
        .blocked   (blocked),
        .direction (direction),
        .dir_change(dir_change),
        .moving    (moving),
        .pend_valid(pend_valid),
        .paused    (paused)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model ----------------
    logic [NB-1:0] m_hist [0:DEB+1];
    logic [NB-1:0] m_deb, m_deb_prev;
    logic [1:0]    m_dir  [NP];
    logic [1:0]    m_pdir [NP];
    bit            m_pend [NP];
    int            m_age  [NP];
    bit            m_paused;
    logic [NP-1:0] e_dc, e_mov, e_pend;
    logic [2*NP-1:0] e_dir;
    logic [3:0]    m_nib;
    int            m_req;
    bit            m_fresh, m_old_paused, m_rise, m_flip;

    function automatic int wanted_heading(input logic e, input logic s, input logic w, input logic n);
        if (e) return 0;
        if (s) return 1;
        if (w) return 2;
        if (n) return 3;
        return -1;
    endfunction

    always @(posedge clock) begin
        if (!resetn) begin
            for (int j = 0; j <= DEB + 1; j++) m_hist[j] = '0;
            m_deb = '0;
            m_deb_prev = '0;
            m_paused = 1'b0;
            e_dc = '0;
            e_mov = '0;
            for (int p = 0; p < NP; p++) begin
                m_dir[p] = 2'd0;
                m_pdir[p] = 2'd0;
                m_pend[p] = 1'b0;
                m_age[p] = 0;
            end
        end else begin
            m_old_paused = m_paused;
            m_rise = |(m_deb[4*NP +: NP] & ~m_deb_prev[4*NP +: NP]);
            for (int p = 0; p < NP; p++) begin
                m_nib = blocked[4*p +: 4];
                e_mov[p] = !m_old_paused && !m_nib[m_dir[p]];
                e_dc[p] = 1'b0;
                m_req = wanted_heading(m_deb[p], m_deb[NP+p], m_deb[2*NP+p], m_deb[3*NP+p]);
                if (m_old_paused) begin
                    m_pend[p] = 1'b0;
                end else begin
                    m_fresh = (m_req >= 0) && (2'(m_req) != m_dir[p]);
                    if (m_fresh && !m_nib[2'(m_req)]) begin
                        m_dir[p] = 2'(m_req);
                        e_dc[p] = 1'b1;
                        m_pend[p] = 1'b0;
                    end
`ifdef INPUT_TURN_BUFFER_EN
                    else if (m_fresh && !(m_pend[p] && m_pdir[p] == 2'(m_req))) begin
                        m_pend[p] = 1'b1;
                        m_pdir[p] = 2'(m_req);
                        m_age[p] = 0;
                    end else if (m_pend[p]) begin
                        if (!m_nib[m_pdir[p]]) begin
                            m_dir[p] = m_pdir[p];
                            e_dc[p] = 1'b1;
                            m_pend[p] = 1'b0;
                        end else if (TO > 0 && m_age[p] >= TO) begin
                            m_pend[p] = 1'b0;
                        end else begin
                            m_age[p] = m_age[p] + 1;
                        end
                    end
`endif
                end
            end
            if (m_rise) m_paused = !m_paused;
            m_deb_prev = m_deb;
            for (int j = DEB + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = {pause_btn, joy_n, joy_w, joy_s, joy_e};
            // the synchronised view of the raw inputs lags by two samples
            for (int b = 0; b < NB; b++) begin
                m_flip = 1'b1;
                for (int j = 2; j <= DEB + 1; j++) begin
                    if (m_hist[j][b] == m_deb[b]) m_flip = 1'b0;
                end
                if (m_flip) m_deb[b] = ~m_deb[b];
            end
        end
        for (int p = 0; p < NP; p++) begin
            e_dir[2*p +: 2] = m_dir[p];
            e_pend[p] = m_pend[p];
        end
        exp_q.push_back({e_dir, e_dc, e_mov, e_pend, m_paused});
    end

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] mon_got, mon_want;

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_want = exp_q.pop_front();
            mon_got = {direction, dir_change, moving, pend_valid, paused};
            n_total++;
            if (mon_got === mon_want) begin
                n_pass++;
            end else begin
                $display("FAIL outputs @%0t: got dir=%b chg=%b mov=%b pend=%b pau=%b, expected dir=%b chg=%b mov=%b pend=%b pau=%b",
                         $time, mon_got[10:7], mon_got[6:5], mon_got[4:3], mon_got[2:1], mon_got[0],
                         mon_want[10:7], mon_want[6:5], mon_want[4:3], mon_want[2:1], mon_want[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    task automatic clear_joy();
        joy_n = '0;
        joy_e = '0;
        joy_s = '0;
        joy_w = '0;
    endtask

    logic [1:0] buf_pend;

    // ---------------- stimulus ----------------
    initial begin
        resetn = 1'b0;
        clear_joy();
        pause_btn = '0;
        blocked = '0;
`ifdef INPUT_TURN_BUFFER_EN
        buf_pend = 2'b01;
`else
        buf_pend = 2'b00;
`endif

        // reset with south held on both players
        joy_s = 2'b11;
        tick(3);
        check("reset_outputs", 16'({direction, dir_change, moving, pend_valid, paused}), 16'h0);
        resetn = 1'b1;
        tick(6);
        check("reset_dir_before_latency", 16'(direction), 16'h0);
        tick(1);
        check("reset_dir_at_latency", 16'(direction), 16'h5);
        check("reset_dir_change_pulse", 16'(dir_change), 16'h3);
        tick(1);
        check("reset_dir_change_one_cycle", 16'(dir_change), 16'h0);
        joy_s = '0;
        tick(8);

        // glitch rejection then a held input
        joy_w[0] = 1'b1;
        tick(3);
        joy_w[0] = 1'b0;
        tick(8);
        check("glitch_ignored", 16'(direction), 16'h5);
        joy_w[0] = 1'b1;
        tick(10);
        check("held_west", 16'(direction), 16'h6);
        joy_w[0] = 1'b0;
        tick(8);

        // buffered turn: east, then north while up is blocked
        joy_e[0] = 1'b1;
        tick(8);
        joy_e[0] = 1'b0;
        tick(8);
        check("p0_east", 16'(direction), 16'h4);
        blocked = 8'h08;
        joy_n[0] = 1'b1;
        tick(8);
        check("buffer_pend_valid", 16'(pend_valid), 16'(buf_pend));
        check("buffer_dir_held", 16'(direction), 16'h4);
        blocked = 8'h00;
        tick(1);
        check("buffer_applied_dir", 16'(direction), 16'h7);
        check("buffer_applied_pulse", 16'(dir_change), 16'h1);
        check("buffer_cleared", 16'(pend_valid), 16'h0);
        joy_n[0] = 1'b0;
        tick(8);

        // timeout of a buffered turn
        joy_e[0] = 1'b1;
        tick(8);
        joy_e[0] = 1'b0;
        tick(8);
        blocked = 8'h08;
        joy_n[0] = 1'b1;
        tick(5);
        joy_n[0] = 1'b0;
        tick(10);
        check("timeout_still_pending", 16'(pend_valid), 16'(buf_pend));
        tick(1);
        check("timeout_dropped", 16'(pend_valid), 16'h0);
        check("timeout_dir_kept", 16'(direction), 16'h4);
        blocked = 8'h00;
        tick(4);

        // pause: simultaneous presses toggle once
        pause_btn = 2'b11;
        tick(5);
        pause_btn = 2'b00;
        tick(3);
        check("pause_set", 16'(paused), 16'h1);
        check("pause_not_moving", 16'(moving), 16'h0);
        joy_s = 2'b11;
        tick(10);
        check("pause_dir_frozen", 16'(direction), 16'h4);
        joy_s = 2'b00;
        tick(10);
        pause_btn = 2'b10;
        tick(5);
        pause_btn = 2'b00;
        tick(3);
        check("pause_released", 16'(paused), 16'h0);
        tick(5);

        // priority: east beats north
        joy_e[1] = 1'b1;
        joy_n[1] = 1'b1;
        tick(10);
        check("priority_east", 16'(direction), 16'h0);
        clear_joy();
        tick(8);

        // randomized segments, including the odd reset and pause press
        for (int seg = 0; seg < 300; seg++) begin
            joy_e = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            joy_s = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            joy_w = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            joy_n = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            pause_btn = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            blocked = 8'($urandom) & 8'($urandom);
            resetn = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            tick($urandom_range(1, 10));
        end

        resetn = 1'b1;
        clear_joy();
        pause_btn = '0;
        blocked = '0;
        tick(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
